norm_frame_ctrl: RTL and testbench
==================================

NORM_FRAME_CTRL -- requirements
Module: norm_frame_ctrl

Interface
REQ-001 SHALL have parameter OUT_ROWS, default 10, meaning cropped image rows.
REQ-002 SHALL have parameter OUT_COLS, default 10, meaning cropped image columns; NPIX = OUT_ROWS*OUT_COLS.
REQ-003 SHALL have parameter COEF_LAT, default 2, meaning cycles from denominator valid to reciprocal valid.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning watchdog limit in RUN.
REQ-005 SHALL have ports, in order: clk in 1 clock; reset in 1 synchronous active-high reset.
REQ-006 SHALL have ports: host_start in 1 frame request; host_denominator in 8 normalization denominator; host_busy out 1; host_done out 1 one-cycle completion pulse; host_error out 1 one-cycle error pulse; frame_count out 16 completed frames.
REQ-007 SHALL have ports: norm_denominator out 8; norm_denominator_tvalid out 1; nr_ap_start out 1; nr_ap_ready in 1; nr_ap_done in 1; seq_ap_idle in 1.
REQ-008 SHALL have ports: pix_tvalid in 1 and pix_tready in 1, a passive monitor of the normalizer input stream; overrun out 1 sticky flag.

Function
REQ-009 SHALL implement states IDLE, LOAD, WAIT_COEF, START, RUN, DONE.
REQ-010 IDLE: host_start=1 with host_denominator!=0 SHALL latch the denominator into norm_denominator and go to LOAD next cycle.
REQ-011 IDLE: host_start=1 with host_denominator==0 SHALL pulse host_error next cycle and remain in IDLE.
REQ-012 host_start outside IDLE SHALL be ignored (no queuing).
REQ-013 norm_denominator_tvalid SHALL be 1 in LOAD, WAIT_COEF, START, RUN; 0 in IDLE and DONE.
REQ-014 LOAD SHALL last 1 cycle, then WAIT_COEF SHALL last exactly COEF_LAT cycles (counter), then START.
REQ-015 START: nr_ap_start SHALL be 1; transition to RUN occurs in the cycle after one where nr_ap_ready=1 and seq_ap_idle=1; nr_ap_start SHALL be 0 in all other states.
REQ-016 RUN: on nr_ap_done=1 SHALL go to DONE; nr_ap_done in any other state SHALL be ignored.
REQ-017 DONE SHALL last 1 cycle: host_done=1, frame_count increments (wraps 0xFFFF->0), then IDLE.
REQ-018 host_busy SHALL be 1 in every state except IDLE.
REQ-019 SHALL count pixel handshakes (pix_tvalid&&pix_tready) only in RUN, cleared on entry to RUN; count width clog2(NPIX+1).
REQ-020 A handshake when count==NPIX SHALL set overrun (sticky) without incrementing; count SHALL saturate at NPIX.
REQ-021 overrun SHALL clear only on reset or on an accepted host_start in IDLE.
REQ-022 nr_ap_done and a pixel handshake in the same RUN cycle SHALL both be honoured (count/overrun updated, DONE entered).

Reset
REQ-023 reset SHALL, on the clock edge, force IDLE, clear all counters, and drive norm_denominator=0, norm_denominator_tvalid=0, nr_ap_start=0, host_busy=0, host_done=0, host_error=0, overrun=0, frame_count=0.
REQ-024 reset asserted mid-frame (any state) SHALL abort without emitting host_done or host_error.

Configuration
REQ-025 Macro NORM_FRAME_CTRL_TIMEOUT_EN SHALL, when defined, compile in a RUN-cycle watchdog counter.
REQ-026 With the macro: TIMEOUT_CYCLES consecutive RUN cycles without nr_ap_done SHALL pulse host_error, skip frame_count increment, and return to IDLE.
REQ-027 Without the macro: no watchdog logic; RUN waits indefinitely for nr_ap_done.

Verification
REQ-028 Nominal: denominator 4, nr_ap_ready=seq_ap_idle=1, 100 pixel handshakes, nr_ap_done -> tvalid high from LOAD, nr_ap_start 1 cycle after COEF_LAT wait, host_done once, frame_count=1, overrun=0.
REQ-029 Zero denominator: host_start with host_denominator=0 -> host_error pulse 1 cycle later, host_busy stays 0, nr_ap_start never asserted.
REQ-030 Backpressure: seq_ap_idle=0 for 20 cycles in START -> nr_ap_start held 20 cycles, RUN entered cycle after seq_ap_idle rises.
REQ-031 Overrun: 101 handshakes in RUN with NPIX=100 -> overrun=1 and stays 1 after host_done; cleared by next accepted host_start.
REQ-032 Reset mid-RUN after 50 pixels -> all outputs at reset values next cycle, no host_done, frame_count unchanged at 0.
REQ-033 With NORM_FRAME_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=100, no nr_ap_done -> host_error after 100 RUN cycles, return to IDLE, frame_count unchanged.

Source files
------------

// File: rtl/norm_frame_ctrl.sv
// Frame sequencer for the normalizer: denominator load, coefficient wait, start handshake,
// pixel-count overrun monitor. Define NORM_FRAME_CTRL_TIMEOUT_EN to add the RUN watchdog.
module norm_frame_ctrl #(
    parameter int OUT_ROWS       = 10,
    parameter int OUT_COLS       = 10,
    parameter int COEF_LAT       = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        host_start,
    input  logic [7:0]  host_denominator,
    output logic        host_busy,
    output logic        host_done,
    output logic        host_error,
    output logic [15:0] frame_count,
    output logic [7:0]  norm_denominator,
    output logic        norm_denominator_tvalid,
    output logic        nr_ap_start,
    input  logic        nr_ap_ready,
    input  logic        nr_ap_done,
    input  logic        seq_ap_idle,
    input  logic        pix_tvalid,
    input  logic        pix_tready,
    output logic        overrun
);
    localparam int NPIX   = OUT_ROWS * OUT_COLS;
    localparam int CNT_W  = $clog2(NPIX + 1);
    localparam int COEF_W = (COEF_LAT > 1) ? $clog2(COEF_LAT) : 1;
    localparam logic [CNT_W-1:0]  PIX_MAX   = CNT_W'(NPIX);
    localparam logic [COEF_W-1:0] COEF_LAST = COEF_W'((COEF_LAT > 0) ? COEF_LAT - 1 : 0);

`ifdef NORM_FRAME_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wd_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, WAIT_COEF, START, RUN, DONE} state_t;

    state_t            state;
    logic [COEF_W-1:0] coef_cnt;
    logic [CNT_W-1:0]  pix_cnt;
    logic              pix_hs;

    assign pix_hs = pix_tvalid && pix_tready;

    // All outputs are registered and updated alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= IDLE;
            coef_cnt                <= '0;
            pix_cnt                 <= '0;
            frame_count             <= '0;
            norm_denominator        <= '0;
            norm_denominator_tvalid <= 1'b0;
            nr_ap_start             <= 1'b0;
            host_busy               <= 1'b0;
            host_done               <= 1'b0;
            host_error              <= 1'b0;
            overrun                 <= 1'b0;
`ifdef NORM_FRAME_CTRL_TIMEOUT_EN
            wd_cnt                  <= '0;
`endif
        end else begin
            host_done  <= 1'b0;
            host_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_start) begin
                        if (host_denominator != 8'd0) begin
                            state                   <= LOAD;
                            norm_denominator        <= host_denominator;
                            norm_denominator_tvalid <= 1'b1;
                            host_busy               <= 1'b1;
                            overrun                 <= 1'b0;
                        end else begin
                            host_error <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    coef_cnt <= '0;
                    if (COEF_LAT == 0) begin
                        state       <= START;
                        nr_ap_start <= 1'b1;
                    end else begin
                        state <= WAIT_COEF;
                    end
                end
                WAIT_COEF: begin
                    if (coef_cnt == COEF_LAST) begin
                        state       <= START;
                        nr_ap_start <= 1'b1;
                    end else begin
                        coef_cnt <= coef_cnt + COEF_W'(1);
                    end
                end
                START: begin
                    if (nr_ap_ready && seq_ap_idle) begin
                        state       <= RUN;
                        nr_ap_start <= 1'b0;
                        pix_cnt     <= '0;
`ifdef NORM_FRAME_CTRL_TIMEOUT_EN
                        wd_cnt      <= '0;
`endif
                    end
                end
                RUN: begin
                    // A handshake past a full frame flags overrun instead of counting.
                    if (pix_hs) begin
                        if (pix_cnt == PIX_MAX) begin
                            overrun <= 1'b1;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                        end
                    end
                    if (nr_ap_done) begin
                        state                   <= DONE;
                        host_done               <= 1'b1;
                        frame_count             <= frame_count + 16'd1;
                        norm_denominator_tvalid <= 1'b0;
                    end
`ifdef NORM_FRAME_CTRL_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        state                   <= IDLE;
                        host_error              <= 1'b1;
                        host_busy               <= 1'b0;
                        norm_denominator_tvalid <= 1'b0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                DONE: begin
                    state     <= IDLE;
                    host_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_norm_frame_ctrl.sv
// Self-checking bench for norm_frame_ctrl: directed frame sequence with randomized
// pixel traffic, checked against a cycle-count and handshake-count model.
module tb_norm_frame_ctrl;
    localparam int ROWS     = 10;
    localparam int COLS     = 10;
    localparam int NPIX     = ROWS * COLS;
    localparam int COEF_LAT = 2;
    localparam int TIMEOUT  = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_start;
    logic [7:0]  host_denominator;
    logic        host_busy;
    logic        host_done;
    logic        host_error;
    logic [15:0] frame_count;
    logic [7:0]  norm_denominator;
    logic        norm_denominator_tvalid;
    logic        nr_ap_start;
    logic        nr_ap_ready;
    logic        nr_ap_done;
    logic        seq_ap_idle;
    logic        pix_tvalid;
    logic        pix_tready;
    logic        overrun;

    int         pass_cnt = 0;
    int         fail_cnt = 0;
    int         check_cnt = 0;
    int         exp_frames = 0;
    int         run_hs = 0;
    logic       model_overrun = 1'b0;
    logic [7:0] cur_den = 8'd0;

    always #5 clk = ~clk;

    norm_frame_ctrl #(
        .OUT_ROWS(ROWS),
        .OUT_COLS(COLS),
        .COEF_LAT(COEF_LAT),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .host_start(host_start),
        .host_denominator(host_denominator),
        .host_busy(host_busy),
        .host_done(host_done),
        .host_error(host_error),
        .frame_count(frame_count),
        .norm_denominator(norm_denominator),
        .norm_denominator_tvalid(norm_denominator_tvalid),
        .nr_ap_start(nr_ap_start),
        .nr_ap_ready(nr_ap_ready),
        .nr_ap_done(nr_ap_done),
        .seq_ap_idle(seq_ap_idle),
        .pix_tvalid(pix_tvalid),
        .pix_tready(pix_tready),
        .overrun(overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Noise that the controller must ignore outside RUN.
    task automatic apply_stimulus(input bit noise);
        if (noise) begin
            pix_tvalid = 1'($urandom_range(0, 1));
            pix_tready = 1'($urandom_range(0, 1));
            nr_ap_done = 1'($urandom_range(0, 1));
            host_start = 1'($urandom_range(0, 1));
        end else begin
            pix_tvalid = 1'b0;
            pix_tready = 1'b0;
            nr_ap_done = 1'b0;
            host_start = 1'b0;
        end
    endtask

    task automatic enter_run(input logic [7:0] den, input int idle_delay);
        cur_den          = den;
        run_hs           = 0;
        nr_ap_ready      = 1'b1;
        seq_ap_idle      = (idle_delay == 0);
        host_start       = 1'b1;
        host_denominator = den;
        step();
        host_start       = 1'b0;
        host_denominator = 8'($urandom);
        model_overrun    = 1'b0;
        check_output("load_busy", host_busy, 1);
        check_output("load_tvalid", norm_denominator_tvalid, 1);
        check_output("load_denominator", norm_denominator, den);
        check_output("load_ap_start", nr_ap_start, 0);
        check_output("load_overrun_cleared", overrun, 0);
        for (int i = 0; i < COEF_LAT; i++) begin
            apply_stimulus(1);
            step();
            check_output("coef_wait_ap_start", nr_ap_start, 0);
            check_output("coef_wait_tvalid", norm_denominator_tvalid, 1);
        end
        apply_stimulus(1);
        step();
        check_output("start_raised", nr_ap_start, 1);
        for (int i = 0; i < idle_delay; i++) begin
            apply_stimulus(1);
            nr_ap_ready = 1'($urandom_range(0, 1));
            step();
            check_output("start_held", nr_ap_start, 1);
        end
        seq_ap_idle = 1'b1;
        nr_ap_ready = 1'b1;
        step();
        apply_stimulus(0);
        check_output("run_ap_start_low", nr_ap_start, 0);
        check_output("run_busy", host_busy, 1);
        check_output("run_tvalid", norm_denominator_tvalid, 1);
    endtask

    task automatic pump_pixels(input int target);
        int budget;
        budget = 4 * target + 20;
        while (run_hs < target && budget > 0) begin
            pix_tvalid = ($urandom_range(0, 7) != 0);
            pix_tready = ($urandom_range(0, 7) != 0);
            host_start = 1'($urandom_range(0, 1));
            if (pix_tvalid && pix_tready) run_hs++;
            step();
            budget--;
            check_output("run_overrun", overrun, (run_hs > NPIX));
            check_output("run_no_done", host_done, 0);
        end
        if (run_hs < target) begin
            check_cnt++;
            fail_cnt++;
            $display("[TB] FAIL pump_budget: handshakes %0d required %0d", run_hs, target);
        end
        apply_stimulus(0);
    endtask

    task automatic finish_frame(input bit with_hs);
        pix_tvalid       = with_hs;
        pix_tready       = with_hs;
        nr_ap_done       = 1'b1;
        host_start       = 1'b1;
        host_denominator = 8'd7;
        if (with_hs) run_hs++;
        exp_frames    = (exp_frames + 1) % 65536;
        model_overrun = (run_hs > NPIX);
        step();
        apply_stimulus(0);
        check_output("done_pulse", host_done, 1);
        check_output("done_frame_count", frame_count, exp_frames);
        check_output("done_overrun", overrun, model_overrun);
        check_output("done_tvalid", norm_denominator_tvalid, 0);
        check_output("done_busy", host_busy, 1);
        check_output("done_denominator", norm_denominator, cur_den);
        step();
        check_output("idle_done_low", host_done, 0);
        check_output("idle_busy", host_busy, 0);
        check_output("idle_error", host_error, 0);
        check_output("idle_frame_count", frame_count, exp_frames);
        check_output("idle_overrun_sticky", overrun, model_overrun);
    endtask

    task automatic zero_denominator();
        host_start       = 1'b1;
        host_denominator = 8'd0;
        step();
        host_start = 1'b0;
        check_output("zero_error_pulse", host_error, 1);
        check_output("zero_busy", host_busy, 0);
        check_output("zero_ap_start", nr_ap_start, 0);
        check_output("zero_tvalid", norm_denominator_tvalid, 0);
        check_output("zero_overrun_kept", overrun, model_overrun);
        step();
        check_output("zero_error_low", host_error, 0);
        check_output("zero_still_idle", host_busy, 0);
        check_output("zero_no_ap_start", nr_ap_start, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"}, host_busy, 0);
        check_output({tag, "_done"}, host_done, 0);
        check_output({tag, "_error"}, host_error, 0);
        check_output({tag, "_tvalid"}, norm_denominator_tvalid, 0);
        check_output({tag, "_ap_start"}, nr_ap_start, 0);
        check_output({tag, "_overrun"}, overrun, 0);
        check_output({tag, "_frame_count"}, frame_count, 0);
        check_output({tag, "_denominator"}, norm_denominator, 0);
    endtask

    initial begin
        reset            = 1'b1;
        host_denominator = 8'd0;
        nr_ap_ready      = 1'b0;
        seq_ap_idle      = 1'b0;
        apply_stimulus(0);
        step();
        step();
        check_reset_values("reset");
        reset = 1'b0;

        // Reset in the middle of a frame aborts silently.
        enter_run(8'd9, 0);
        pump_pixels(50);
        reset = 1'b1;
        step();
        reset         = 1'b0;
        exp_frames    = 0;
        model_overrun = 1'b0;
        check_reset_values("midrun_reset");
        step();
        check_output("post_reset_no_done", host_done, 0);
        check_output("post_reset_no_error", host_error, 0);

        // Nominal frame, exactly one full image.
        enter_run(8'd4, 0);
        pump_pixels(NPIX);
        finish_frame(0);

        zero_denominator();

        // Sequencer not idle for 20 cycles while start is requested.
        enter_run(8'($urandom_range(1, 255)), 20);
        pump_pixels($urandom_range(0, NPIX));
        finish_frame(0);

        // One handshake beyond a full image.
        enter_run(8'($urandom_range(1, 255)), 0);
        pump_pixels(NPIX + 1);
        finish_frame(0);
        zero_denominator();
        enter_run(8'($urandom_range(1, 255)), 1);
        pump_pixels(NPIX - 1);
        finish_frame(1);

        for (int f = 0; f < 6; f++) begin
            logic [7:0] den;
            den = 8'($urandom_range(0, 255));
            if (f == 2) den = 8'd0;
            if (den == 8'd0) begin
                zero_denominator();
            end else begin
                enter_run(den, $urandom_range(0, 5));
                pump_pixels($urandom_range(NPIX - 3, NPIX + 3));
                finish_frame(1'($urandom_range(0, 1)));
            end
        end

`ifdef NORM_FRAME_CTRL_TIMEOUT_EN
        enter_run(8'd5, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step();
            check_output("wd_wait_error", host_error, 0);
        end
        check_output("wd_wait_busy", host_busy, 1);
        step();
        check_output("wd_error_pulse", host_error, 1);
        check_output("wd_busy", host_busy, 0);
        check_output("wd_tvalid", norm_denominator_tvalid, 0);
        check_output("wd_no_done", host_done, 0);
        check_output("wd_frame_count", frame_count, exp_frames);
        step();
        check_output("wd_error_low", host_error, 0);
`else
        enter_run(8'd5, 0);
        for (int i = 0; i < 150; i++) begin
            step();
            check_output("long_run_error", host_error, 0);
        end
        check_output("long_run_busy", host_busy, 1);
        finish_frame(0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
